// File: rtl/ddr_event_emulator.sv
// ddr_event_emulator: DDR3 page/event stand-in behind the DATAREQ interface.
// Ports:
//   readout_clk, resetn (async, active-low)
//   write side : wr_en, write_page_no -> ddr_full, mem_wr_cnt
//   request    : datareq_start, datareq_re, evt_pkts, pattern_sel
//   reply      : data_ready, last_word, pkts_in_event, data
//   stats      : mem_rd_cnt, word_rd_cnt, drop_cnt
module ddr_event_emulator #(
    parameter int DATA_W      = 64,
    parameter int BLOCK_PKTS  = 64,
    parameter int PKT_WORDS   = 2,
    parameter int WR_PAGE_CYC = 1,
    parameter int EMPTY_HOLD  = 8
) (
    input  logic              readout_clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [31:0]       write_page_no,
    input  logic [15:0]       evt_pkts,
    input  logic [1:0]        pattern_sel,
    input  logic              datareq_start,
    input  logic              datareq_re,
    output logic              ddr_full,
    output logic [31:0]       mem_wr_cnt,
    output logic [31:0]       mem_rd_cnt,
    output logic [31:0]       word_rd_cnt,
    output logic [15:0]       drop_cnt,
    output logic              data_ready,
    output logic              last_word,
    output logic [15:0]       pkts_in_event,
    output logic [DATA_W-1:0] data
);
    localparam int L = DATA_W / 32;

    typedef enum logic [1:0] {W_IDLE, W_RUN, W_FULL} wr_state_t;
    typedef enum logic [2:0] {R_IDLE, R_EMPTY, R_REPLY, R_LAST, R_WRAP} rd_state_t;

    wr_state_t         wr_st_q, wr_st_d;
    rd_state_t         rd_st_q, rd_st_d;
    logic              wr_en_q, start_q;
    logic              full_q, full_d;
    logic [31:0]       plim_q, plim_d;
    logic [31:0]       pcyc_q, pcyc_d;
    logic [31:0]       wcnt_q, wcnt_d;
    logic [31:0]       rcnt_q, rcnt_d;
    logic [31:0]       words_q, words_d;
    logic [15:0]       drop_q, drop_d;
    logic [15:0]       k_q, k_d;
    logic [1:0]        mode_q, mode_d;
    logic [15:0]       page_q, page_d;
    logic [31:0]       w_q, w_d;
    logic [31:0]       wlast_q, wlast_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       n_q, n_d;
    logic [30:0]       lfsr_q, lfsr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       k_sel;
    logic              wr_edge, start_edge;

    // PRBS-31, x^31 + x^28 + 1, shifting toward the MSB
    function automatic logic [30:0] lfsr_nx(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction

    function automatic logic [30:0] lfsr_adv(input logic [30:0] s);
        logic [30:0] t;
        t = s;
        for (int i = 0; i < L; i++) t = lfsr_nx(t);
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] payload(
        input logic [1:0]  md,
        input logic [31:0] n,
        input logic [31:0] w,
        input logic [15:0] pg,
        input logic [30:0] s
    );
        logic [DATA_W-1:0] r;
        logic [30:0]       t;
        r = '0;
        t = s;
        for (int k = 0; k < L; k++) begin
            case (md)
                2'd0: r[32*k +: 32] = n * 32'(L) + 32'(k);
                2'd1: r[32*k +: 32] = {pg, 16'(w * 32'(L) + 32'(k))};
                2'd2: begin
                    r[32*k +: 32] = {1'b0, t};
                    t = lfsr_nx(t);
                end
                default: r[32*k +: 32] = 32'hDEAD_BEEF;
            endcase
        end
        return r;
    endfunction

    assign wr_edge    = wr_en & ~wr_en_q;
    assign start_edge = datareq_start & ~start_q;
    assign k_sel      = (evt_pkts == 16'd0) ? 16'(BLOCK_PKTS) : evt_pkts;

    // Write FSM; the read side's wrap cycle overrides it
    always_comb begin
        wr_st_d = wr_st_q;
        full_d  = full_q;
        plim_d  = plim_q;
        pcyc_d  = pcyc_q;
        wcnt_d  = wcnt_q;
        case (wr_st_q)
            W_IDLE: begin
                if (wr_edge && write_page_no != 32'd0) begin
                    plim_d  = write_page_no;
                    pcyc_d  = '0;
                    wr_st_d = W_RUN;
                end
            end
            W_RUN: begin
                if (wcnt_q == plim_q) begin
                    full_d  = 1'b1;
                    wr_st_d = W_FULL;
                end else if (wr_en) begin
                    if (pcyc_q == 32'(WR_PAGE_CYC - 1)) begin
                        pcyc_d = '0;
                        wcnt_d = wcnt_q + 32'd1;
                    end else begin
                        pcyc_d = pcyc_q + 32'd1;
                    end
                end
            end
            default: ;
        endcase
        if (rd_st_q == R_WRAP) begin
            full_d  = 1'b0;
            wcnt_d  = '0;
            wr_st_d = W_IDLE;
        end
    end

    // Read FSM and payload generation
    always_comb begin
        rd_st_d = rd_st_q;
        rcnt_d  = rcnt_q;
        words_d = words_q;
        drop_d  = drop_q;
        k_d     = k_q;
        mode_d  = mode_q;
        page_d  = page_q;
        w_d     = w_q;
        wlast_d = wlast_q;
        hold_d  = hold_q;
        n_d     = n_q;
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        if (start_edge && rd_st_q != R_IDLE && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
        case (rd_st_q)
            R_IDLE: begin
                if (start_edge) begin
                    if (!full_q) begin
                        hold_d  = '0;
                        rd_st_d = R_EMPTY;
                    end else begin
                        rcnt_d  = rcnt_q + 32'd1;
                        k_d     = k_sel;
                        mode_d  = pattern_sel;
                        page_d  = rcnt_q[15:0];
                        w_d     = '0;
                        wlast_d = 32'(k_sel) * 32'(PKT_WORDS) - 32'd1;
                        data_d  = payload(pattern_sel, n_q, 32'd0,
                                          rcnt_q[15:0], lfsr_q);
                        rd_st_d = R_REPLY;
                    end
                end
            end
            R_EMPTY: begin
                if (hold_q == 32'(EMPTY_HOLD - 1)) rd_st_d = R_IDLE;
                else hold_d = hold_q + 32'd1;
            end
            R_REPLY: begin
                if (datareq_re) begin
                    words_d = words_q + 32'd1;
                    if (mode_q == 2'd0) n_d = n_q + 32'd1;
                    if (mode_q == 2'd2) lfsr_d = lfsr_adv(lfsr_q);
                    if (w_q == wlast_q) begin
                        data_d  = '0;
                        rd_st_d = R_LAST;
                    end else begin
                        w_d    = w_q + 32'd1;
                        data_d = payload(mode_q, n_d, w_d, page_q, lfsr_d);
                    end
                end
            end
            R_LAST: rd_st_d = (rcnt_q == plim_q) ? R_WRAP : R_IDLE;
            R_WRAP: begin
                rcnt_d  = '0;
                rd_st_d = R_IDLE;
            end
            default: rd_st_d = R_IDLE;
        endcase
    end

    always_ff @(posedge readout_clk or negedge resetn) begin
        if (!resetn) begin
            wr_st_q <= W_IDLE;
            rd_st_q <= R_IDLE;
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            full_q  <= 1'b0;
            plim_q  <= '0;
            pcyc_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            words_q <= '0;
            drop_q  <= '0;
            k_q     <= '0;
            mode_q  <= '0;
            page_q  <= '0;
            w_q     <= '0;
            wlast_q <= '0;
            hold_q  <= '0;
            n_q     <= '0;
            lfsr_q  <= 31'd1;
            data_q  <= '0;
        end else begin
            wr_st_q <= wr_st_d;
            rd_st_q <= rd_st_d;
            wr_en_q <= wr_en;
            start_q <= datareq_start;
            full_q  <= full_d;
            plim_q  <= plim_d;
            pcyc_q  <= pcyc_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            words_q <= words_d;
            drop_q  <= drop_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            page_q  <= page_d;
            w_q     <= w_d;
            wlast_q <= wlast_d;
            hold_q  <= hold_d;
            n_q     <= n_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
        end
    end

    assign ddr_full      = full_q;
    assign mem_wr_cnt    = wcnt_q;
    assign mem_rd_cnt    = rcnt_q;
    assign word_rd_cnt   = words_q;
    assign drop_cnt      = drop_q;
    assign data_ready    = (rd_st_q == R_EMPTY) || (rd_st_q == R_REPLY) ||
                           (rd_st_q == R_LAST);
    assign last_word     = (rd_st_q == R_LAST);
    assign pkts_in_event = ((rd_st_q == R_REPLY) || (rd_st_q == R_LAST)) ? k_q : 16'd0;
    assign data          = data_q;
endmodule

// File: tb/tb_ddr_event_emulator.sv
// tb_ddr_event_emulator: directed vectors and event sequences for
// ddr_event_emulator with default parameters (DATA_W = 64, two lanes).
module tb_ddr_event_emulator;
    logic        readout_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] write_page_no = '0;
    logic [15:0] evt_pkts = '0;
    logic [1:0]  pattern_sel = '0;
    logic        datareq_start = 1'b0;
    logic        datareq_re = 1'b0;
    logic        ddr_full;
    logic [31:0] mem_wr_cnt, mem_rd_cnt, word_rd_cnt;
    logic [15:0] drop_cnt, pkts_in_event;
    logic        data_ready, last_word;
    logic [63:0] data;

    ddr_event_emulator dut (
        .readout_clk  (readout_clk),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .write_page_no(write_page_no),
        .evt_pkts     (evt_pkts),
        .pattern_sel  (pattern_sel),
        .datareq_start(datareq_start),
        .datareq_re   (datareq_re),
        .ddr_full     (ddr_full),
        .mem_wr_cnt   (mem_wr_cnt),
        .mem_rd_cnt   (mem_rd_cnt),
        .word_rd_cnt  (word_rd_cnt),
        .drop_cnt     (drop_cnt),
        .data_ready   (data_ready),
        .last_word    (last_word),
        .pkts_in_event(pkts_in_event),
        .data         (data)
    );

    always #5 readout_clk = ~readout_clk;

    typedef struct {
        logic        we;
        logic [31:0] wpn;
        logic        st;
        logic        re;
        logic        full;
        logic [31:0] wc;
        logic [31:0] rc;
        logic        rdy;
        logic        last;
        logic [15:0] pk;
        logic [63:0] dat;
        logic [31:0] wrd;
        logic [15:0] drop;
    } vec_t;

    vec_t        tbl[$];
    int          nvec = 0;
    int          nbad = 0;
    logic [31:0] m_n;
    logic [30:0] m_lfsr;
    logic [63:0] w0, w1;

    task automatic tick();
        @(posedge readout_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] wpn, input logic st,
                                input logic re, input logic full, input logic [31:0] wc,
                                input logic [31:0] rc, input logic rdy, input logic last,
                                input logic [15:0] pk, input logic [63:0] dat,
                                input logic [31:0] wrd, input logic [15:0] drop);
        vec_t v;
        v = '{we, wpn, st, re, full, wc, rc, rdy, last, pk, dat, wrd, drop};
        tbl.push_back(v);
    endfunction

    function automatic logic [30:0] nx(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction

    function automatic logic [63:0] expw(input logic [1:0] md, input logic [15:0] pg, input int w);
        case (md)
            2'd0: return {m_n * 32'd2 + 32'd1, m_n * 32'd2};
            2'd1: return {pg, 16'(w * 2 + 1), pg, 16'(w * 2)};
            2'd2: return {1'b0, nx(m_lfsr), 1'b0, m_lfsr};
            default: return {2{32'hDEAD_BEEF}};
        endcase
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        wr_en = 1'b0;
        write_page_no = '0;
        evt_pkts = '0;
        pattern_sel = '0;
        datareq_start = 1'b0;
        datareq_re = 1'b0;
        tick();
        chk("reset data", data, 64'd0);
        chk("reset flags", {ddr_full, data_ready, last_word, pkts_in_event, drop_cnt}, 64'd0);
        chk("reset cnts", {mem_wr_cnt | mem_rd_cnt, word_rd_cnt}, 64'd0);
        resetn = 1'b1;
        tick();
    endtask

    task automatic write_pages(input logic [31:0] p);
        int g;
        g = 0;
        write_page_no = p;
        wr_en = 1'b1;
        while (!ddr_full && g < 200) begin
            tick();
            g++;
        end
        chk("write full", ddr_full, 1);
        chk("write cnt", mem_wr_cnt, p);
        wr_en = 1'b0;
        write_page_no = '0;
        tick();
    endtask

    task automatic run_event(input logic [1:0] md, input logic [15:0] pk, input logic [15:0] pg,
                             input int nwords, input string nm);
        int words;
        int errs;
        words = 0;
        errs = 0;
        evt_pkts = pk;
        pattern_sel = md;
        datareq_start = 1'b1;
        tick();
        datareq_start = 1'b0;
        datareq_re = 1'b1;
        chk({nm, " rdy"}, data_ready, 1);
        chk({nm, " pkts"}, pkts_in_event, (pk == 16'd0) ? 64'd64 : 64'(pk));
        while (!last_word && words < 1000) begin
            if (words == 0) w0 = data;
            if (words == 1) w1 = data;
            if (data !== expw(md, pg, words)) errs++;
            if (md == 2'd0) m_n = m_n + 32'd1;
            if (md == 2'd2) m_lfsr = nx(nx(m_lfsr));
            words++;
            tick();
        end
        datareq_re = 1'b0;
        chk({nm, " last_word"}, last_word, 1);
        chk({nm, " words"}, 64'(words), 64'(nwords));
        chk({nm, " data errs"}, 64'(errs), 64'd0);
        tick();
    endtask

    initial begin
        // we wpn st re | full wc rc rdy last pk data wrd drop
        add(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 3, 0, 0, 0, 3, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 64'h0, 0, 0);
        add(0, 3, 0, 0, 1, 3, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 64'h0, 0, 0);
        add(1, 0, 1, 0, 1, 3, 1, 1, 0, 3, 64'h00000001_00000000, 0, 0);
        add(1, 0, 0, 0, 1, 3, 1, 1, 0, 3, 64'h00000001_00000000, 0, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 0, 3, 64'h00000003_00000002, 1, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 0, 3, 64'h00000005_00000004, 2, 0);
        add(1, 0, 0, 0, 1, 3, 1, 1, 0, 3, 64'h00000005_00000004, 2, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 0, 3, 64'h00000007_00000006, 3, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 0, 3, 64'h00000009_00000008, 4, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 0, 3, 64'h0000000B_0000000A, 5, 0);
        add(1, 0, 0, 1, 1, 3, 1, 1, 1, 3, 64'h0, 6, 0);
        add(1, 0, 0, 0, 1, 3, 1, 0, 0, 0, 64'h0, 6, 0);
        add(1, 0, 1, 0, 1, 3, 2, 1, 0, 3, 64'h00010001_00010000, 6, 0);
        add(1, 0, 0, 1, 1, 3, 2, 1, 0, 3, 64'h00010003_00010002, 7, 0);
        add(1, 0, 1, 1, 1, 3, 2, 1, 0, 3, 64'h00010005_00010004, 8, 1);
        add(1, 0, 0, 1, 1, 3, 2, 1, 0, 3, 64'h00010007_00010006, 9, 1);
        add(1, 0, 0, 1, 1, 3, 2, 1, 0, 3, 64'h00010009_00010008, 10, 1);
        add(1, 0, 0, 1, 1, 3, 2, 1, 0, 3, 64'h0001000B_0001000A, 11, 1);
        add(1, 0, 0, 1, 1, 3, 2, 1, 1, 3, 64'h0, 12, 1);
        add(1, 0, 0, 0, 1, 3, 2, 0, 0, 0, 64'h0, 12, 1);
        add(1, 0, 1, 0, 1, 3, 3, 1, 0, 3, 64'h00020001_00020000, 12, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 0, 3, 64'h00020003_00020002, 13, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 0, 3, 64'h00020005_00020004, 14, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 0, 3, 64'h00020007_00020006, 15, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 0, 3, 64'h00020009_00020008, 16, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 0, 3, 64'h0002000B_0002000A, 17, 1);
        add(1, 0, 0, 1, 1, 3, 3, 1, 1, 3, 64'h0, 18, 1);
        add(1, 0, 0, 0, 1, 3, 3, 0, 0, 0, 64'h0, 18, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 64'h0, 18, 1);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 64'h0, 18, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 18, 1);

        // Table: paged writes, tagged replies with stall and drop, wrap, empty reply
        do_reset();
        evt_pkts = 16'd3;
        pattern_sel = 2'd1;
        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].we;
            write_page_no = tbl[i].wpn;
            datareq_start = tbl[i].st;
            datareq_re = tbl[i].re;
            tick();
            nvec++;
            if ({ddr_full, mem_wr_cnt, mem_rd_cnt, data_ready, last_word, pkts_in_event,
                 data, word_rd_cnt, drop_cnt} !==
                {tbl[i].full, tbl[i].wc, tbl[i].rc, tbl[i].rdy, tbl[i].last, tbl[i].pk,
                 tbl[i].dat, tbl[i].wrd, tbl[i].drop}) begin
                nbad++;
                $display("FAIL vec%0d: got full=%b wc=%0d rc=%0d rdy=%b last=%b pk=%0d d=%h wrd=%0d drop=%0d want full=%b wc=%0d rc=%0d rdy=%b last=%b pk=%0d d=%h wrd=%0d drop=%0d",
                         i, ddr_full, mem_wr_cnt, mem_rd_cnt, data_ready, last_word,
                         pkts_in_event, data, word_rd_cnt, drop_cnt, tbl[i].full,
                         tbl[i].wc, tbl[i].rc, tbl[i].rdy, tbl[i].last, tbl[i].pk,
                         tbl[i].dat, tbl[i].wrd, tbl[i].drop);
            end
        end

        // Counter mode, default block size, three pages then wrap
        do_reset();
        write_pages(3);
        m_n = '0;
        run_event(2'd0, 16'd0, 16'd0, 128, "m0e1");
        chk("m0 first word", w0, 64'h00000001_00000000);
        run_event(2'd0, 16'd0, 16'd1, 128, "m0e2");
        chk("m0 e2 first word", w0, 64'h00000101_00000100);
        run_event(2'd0, 16'd0, 16'd2, 128, "m0e3");
        tick();
        chk("wrap full", ddr_full, 0);
        chk("wrap cnts", {mem_wr_cnt, mem_rd_cnt}, 64'd0);
        chk("m0 word_rd_cnt", word_rd_cnt, 64'd384);

        // PRBS-31 across two events
        do_reset();
        write_pages(2);
        m_lfsr = 31'd1;
        run_event(2'd2, 16'd8, 16'd0, 16, "m2e1");
        chk("m2 w0", w0, 64'h00000002_00000001);
        chk("m2 w1", w1, 64'h00000008_00000004);
        run_event(2'd2, 16'd8, 16'd1, 16, "m2e2");
        chk("m2 e2 w0", w0, 64'h00000024_00000012);

        // Reset in the middle of a constant-mode event, then restart
        do_reset();
        write_pages(1);
        evt_pkts = 16'd4;
        pattern_sel = 2'd3;
        datareq_start = 1'b1;
        tick();
        datareq_start = 1'b0;
        datareq_re = 1'b1;
        tick();
        tick();
        chk("pre-reset rdy", data_ready, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async rst data", data, 64'd0);
        chk("async rst flags", {ddr_full, data_ready, last_word, pkts_in_event, drop_cnt}, 64'd0);
        chk("async rst cnts", {mem_wr_cnt | mem_rd_cnt, word_rd_cnt}, 64'd0);
        datareq_re = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        chk("post-reset last", last_word, 0);
        write_pages(1);
        run_event(2'd3, 16'd1, 16'd0, 2, "m3");
        chk("m3 w0", w0, 64'hDEADBEEF_DEADBEEF);
        chk("m3 w1", w1, 64'hDEADBEEF_DEADBEEF);
        chk("m3 word_rd_cnt", word_rd_cnt, 64'd2);
        tick();
        chk("m3 wrap full", ddr_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/ddr_event_emulator.md
# ddr_event_emulator

Parametrised successor to the DDR3 page emulator on the readout path. It stands in for DDR3 behind the DATAREQ interface: it fills a configurable number of pages, answers data requests with events of configurable size and payload pattern, and wraps automatically once every stored page has been read back. It sits between the DRACMonitor register map and the DATAREQ reply logic, in the `readout_clk` (40 MHz) domain.

## Interface

Parameters:
- `DATA_W`, 64: reply word width; must be a multiple of 32 and at least 64. `L = DATA_W/32` lanes.
- `BLOCK_PKTS`, 64: default packets per event, used when `evt_pkts == 0`.
- `PKT_WORDS`, 2: reply words per packet.
- `WR_PAGE_CYC`, 1: cycles per emulated page write (at least 1).
- `EMPTY_HOLD`, 8: cycles an empty reply is held.

Ports:
- `readout_clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: level; emulated page writing.
- `write_page_no` in 32: pages to write; sampled on the rising edge of `wr_en`.
- `evt_pkts` in 16: packets per event; 0 selects `BLOCK_PKTS`; sampled at request.
- `pattern_sel` in 2: payload mode; sampled at request.
- `datareq_start` in 1: data request; acts on its rising edge.
- `datareq_re` in 1: word pop, level, one word per cycle.
- `ddr_full` out 1: all requested pages written.
- `mem_wr_cnt` out 32: pages written.
- `mem_rd_cnt` out 32: pages read.
- `word_rd_cnt` out 32: total words popped; cleared only by reset.
- `drop_cnt` out 16: requests ignored while busy; saturates at 0xFFFF.
- `data_ready` out 1: reply valid.
- `last_word` out 1: end-of-event pulse.
- `pkts_in_event` out 16: packets in the current reply.
- `data` out `DATA_W`: current reply word.

## Operation

- Reset value of every output: 0. Internal LFSR = 0x0000_0001, run counter `n` = 0.
- Write FSM states:
  - `W_IDLE`: on the rising edge of `wr_en` with `write_page_no != 0`, latch `P = write_page_no` and go to `W_RUN`. A value of 0 is ignored.
  - `W_RUN`: `mem_wr_cnt` +1 every `WR_PAGE_CYC` cycles while `wr_en` is high; writing pauses while `wr_en` is low. When `mem_wr_cnt == P`, assert `ddr_full` and go to `W_FULL`.
  - `W_FULL`: hold. Further `wr_en` edges are ignored.
- Read FSM states:
  - `R_IDLE`: on the rising edge of `datareq_start`:
    - if `ddr_full` is low, go to `R_EMPTY`;
    - else `mem_rd_cnt` +1, latch `K` (packets, from `evt_pkts` or `BLOCK_PKTS`), the mode, and page `p = mem_rd_cnt` (pre-increment); go to `R_REPLY`.
  - `R_EMPTY`: `data_ready = 1`, `pkts_in_event = 0` for `EMPTY_HOLD` cycles, then return to `R_IDLE`.
  - `R_REPLY`: `data_ready = 1`, `pkts_in_event = K`. Each cycle with `datareq_re` high pops one word. After word `K*PKT_WORDS - 1` is popped, go to `R_LAST`.
  - `R_LAST`: one cycle with `last_word = 1` and `data_ready = 1`. Then, if `mem_rd_cnt == P`, go to `R_WRAP`; else go to `R_IDLE`.
  - `R_WRAP`: one cycle. Clear `ddr_full`, `mem_wr_cnt` and `mem_rd_cnt`; the write FSM returns to `W_IDLE`. Wrap-around is synchronous.
- A `datareq_start` rising edge in any state other than `R_IDLE` is dropped and increments `drop_cnt`. `datareq_re` outside `R_REPLY` is ignored.
- Payload, for lane k (bits `32k+31:32k`), word index w within the event, and page p:
  - mode 0 (counter): lane = `n*L + k` (mod 2^32). `n` +1 per pop and continues across events.
  - mode 1 (tagged): lane = `{p[15:0], (w*L+k)[15:0]}`.
  - mode 2 (PRBS-31, x^31+x^28+1): lanes are L successive LFSR states, lane 0 being the current state. The LFSR advances L steps per pop and persists across events.
  - mode 3 (constant): all lanes = 0xDEAD_BEEF.
- `word_rd_cnt` +1 per pop and wraps at 2^32.
- Reset mid-event: outputs go to 0 immediately; no `last_word` is produced.

## Timing

- The `datareq_start` edge is detected from a registered copy: the edge is seen at cycle t when `datareq_start` is high at t and was low at t-1. `data_ready`, `pkts_in_event` and word 0 on `data` are valid at t+1.
- `data` is registered: a pop at cycle t presents the next word at t+1. Zero-bubble streaming at one word per cycle is supported.
- Last pop at t: `last_word` at t+1, `data_ready` low at t+2. With a wrap, `ddr_full` is low at t+3.
- The earliest next accepted request edge is at t+2, or t+3 after a wrap.
- `ddr_full` rises the cycle after `mem_wr_cnt` reaches P. With `WR_PAGE_CYC = 1`, the first page increment lands 1 cycle after the `wr_en` edge.
- Empty reply: request edge at t gives `data_ready` high at t+1..t+`EMPTY_HOLD`.

## Test plan

- Reset, `write_page_no = 3`, `wr_en` held high → `mem_wr_cnt` 1, 2, 3 on consecutive cycles; `ddr_full` = 1 one cycle later; `write_page_no = 0` produces no writes.
- `ddr_full = 0`, request → `data_ready = 1` and `pkts_in_event = 0` for exactly 8 cycles; no `last_word`; `mem_rd_cnt` stays 0.
- 3 pages, `evt_pkts = 0`, mode 0, `datareq_re` high continuously → 128 words per event, first word 0x00000001_00000000; `last_word` after 128 pops; the third event is followed by a wrap with `ddr_full`, `mem_wr_cnt` and `mem_rd_cnt` = 0; `word_rd_cnt` = 384.
- `evt_pkts = 3`, mode 1, page 2 → 6 words, word 5 = 0x0002000B_0002000A; stalling `datareq_re` holds `data` stable.
- Mode 2 → word 0 lanes 0x00000001 then the next LFSR state; values continue correctly across two events. Mode 3 → every lane 0xDEADBEEF.
- Second request mid-reply → `drop_cnt` = 1, reply unaffected. `resetn` low mid-event → all outputs 0 asynchronously, then a normal restart.
